// File: rtl/adf_spi_serializer.sv
// adf_spi_serializer: ADF4351 3-wire (CLK/DATA/LE) serial register write engine
// Shifts a WORD_W-bit register word out MSB first on ADF_CLK/ADF_DATA, pulses
// ADF_LE to latch it into the PLL, then pulses ADF_WRITE_DONE for one cycle.
// Ports:
//   CLK, RST        system clock, asynchronous active-low reset
//   WEN, WDATA      write strobe and register word, accepted only while idle
//   ADF_CLK         serial clock to the PLL (idles low)
//   ADF_DATA        serial data, stable around every ADF_CLK rising edge
//   ADF_LE          load-enable pulse that latches the shifted word
//   ADF_WRITE_DONE  one-cycle pulse once the word has been latched
//   BUSY            high from the accepting edge until the return to IDLE
// Build option ADF_SPI_HOLD_EN: adds a one-entry holding register that keeps one
// word written while BUSY and starts it directly from the DONE cycle.
module adf_spi_serializer #(
  parameter int CLK_DIV     = 4,
  parameter int LE_HIGH_CYC = 2,
  parameter int WORD_W      = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WEN,
  input  logic [WORD_W-1:0] WDATA,
  output logic              ADF_CLK,
  output logic              ADF_DATA,
  output logic              ADF_LE,
  output logic              ADF_WRITE_DONE,
  output logic              BUSY
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOW   = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_GUARD = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam int CMAX = (CLK_DIV > LE_HIGH_CYC) ? CLK_DIV : LE_HIGH_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(WORD_W);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LE_LAST  = CW'(LE_HIGH_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              sclk_q, sclk_d;
  logic              data_q, data_d;
  logic              le_q, le_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              launch;
  logic [WORD_W-1:0] launch_word;
  logic              div_end, le_end;

  assign div_end = cnt_q == DIV_LAST;
  assign le_end  = cnt_q == LE_LAST;

`ifdef ADF_SPI_HOLD_EN
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_v_q, hold_v_d;

  // A held word launches from DONE (back-to-back) or, if it was captured on the
  // DONE cycle itself, from the IDLE cycle that follows.
  always_comb begin
    hold_d      = hold_q;
    hold_v_d    = hold_v_q;
    launch      = state_q == S_IDLE && WEN;
    launch_word = WDATA;
    if (busy_q && !hold_v_q && WEN) begin
      hold_d   = WDATA;
      hold_v_d = 1'b1;
    end
    if (hold_v_q && (state_q == S_DONE || state_q == S_IDLE)) begin
      launch      = 1'b1;
      launch_word = hold_q;
      hold_v_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
    end
`else
  always_comb begin
    launch      = state_q == S_IDLE && WEN;
    launch_word = WDATA;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    data_d  = data_q;
    le_d    = le_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    if (launch) begin
      state_d = S_LOW;
      cnt_d   = '0;
      bit_d   = BIT_LAST;
      shift_d = launch_word;
      sclk_d  = 1'b0;
      data_d  = launch_word[WORD_W-1];
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_LOW: begin
          cnt_d = div_end ? '0 : cnt_q + 1'b1;
          if (div_end) begin
            state_d = S_HIGH;
            sclk_d  = 1'b1;
          end
        end
        S_HIGH: begin
          cnt_d = div_end ? '0 : cnt_q + 1'b1;
          if (div_end) begin
            sclk_d = 1'b0;
            // Data moves on the falling edge, giving a full half-period of
            // hold after the rise just completed and setup before the next.
            if (bit_q != '0) begin
              state_d = S_LOW;
              bit_d   = bit_q - 1'b1;
              shift_d = {shift_q[WORD_W-2:0], 1'b0};
              data_d  = shift_q[WORD_W-2];
            end else begin
              state_d = S_GUARD;
            end
          end
        end
        S_GUARD: begin
          cnt_d = div_end ? '0 : cnt_q + 1'b1;
          if (div_end) begin
            state_d = S_LATCH;
            le_d    = 1'b1;
          end
        end
        S_LATCH: begin
          cnt_d = le_end ? '0 : cnt_q + 1'b1;
          if (le_end) begin
            state_d = S_DONE;
            le_d    = 1'b0;
            done_d  = 1'b1;
            data_d  = 1'b0;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b0;
      data_q  <= 1'b0;
      le_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      data_q  <= data_d;
      le_q    <= le_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end

  assign ADF_CLK        = sclk_q;
  assign ADF_DATA       = data_q;
  assign ADF_LE         = le_q;
  assign ADF_WRITE_DONE = done_q;
  assign BUSY           = busy_q;
endmodule
